// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and helpers for the RV32I hazard controller
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } hz_state_e;

    // Operand source selects, shared with the EX-stage forwarding unit.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EX_MEM  = 2'b10,
        FWD_MEM_WB  = 2'b01
    } fwd_sel_e;

    function automatic logic load_use_hit(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  uses_rs1,
        input logic                  uses_rs2
    );
        return mem_read && (rd != '0) &&
               (((rd == rs1) && uses_rs1) || ((rd == rs2) && uses_rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] if_id_rs1;
    logic [REG_ADDR_W-1:0] if_id_rs2;
    logic                  if_id_uses_rs1;
    logic                  if_id_uses_rs2;
    logic                  id_ex_MemRead;
    logic [REG_ADDR_W-1:0] id_ex_RegisterRd;
    logic                  ex_branch_taken;
    logic                  ex_mc_start;
    logic                  ex_mc_done;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_write;
    logic                  id_ex_flush;
    logic                  ex_mem_bubble;
    logic                  mc_busy;
    logic                  mc_timeout_err;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
               id_ex_MemRead, id_ex_RegisterRd, ex_branch_taken, ex_mc_start, ex_mc_done,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble,
               mc_busy, mc_timeout_err, stall_cycles, flush_count
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
               id_ex_MemRead, id_ex_RegisterRd, ex_branch_taken, ex_mc_start, ex_mc_done,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble,
               mc_busy, mc_timeout_err, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating up-counter that holds at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for load-use, taken branches and mul/div
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int             TO_W    = $clog2(MC_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

    hz_state_e        r_state;
    hz_state_e        w_next_state;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_timeout_err;

    logic             w_load_use;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_if_id_flush;
    logic             w_id_ex_write;
    logic             w_id_ex_flush;
    logic             w_ex_mem_bubble;
    logic             w_flush_inc;
    logic             w_to_expire;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    assign w_load_use = load_use_hit(bus.id_ex_MemRead, bus.id_ex_RegisterRd,
                                     bus.if_id_rs1, bus.if_id_rs2,
                                     bus.if_id_uses_rs1, bus.if_id_uses_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_write   = 1'b1;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_flush_inc     = 1'b0;
        w_to_expire     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_flush_inc   = 1'b1;
                end else if (bus.ex_mc_start) begin
                    // A start with done in the same cycle is a single-cycle op.
                    if (!bus.ex_mc_done) begin
                        w_pc_write      = 1'b0;
                        w_if_id_write   = 1'b0;
                        w_id_ex_write   = 1'b0;
                        w_ex_mem_bubble = 1'b1;
                        w_next_state    = ST_MC_WAIT;
                    end
                end else if (w_load_use) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                if (bus.ex_mc_done) begin
                    w_next_state = ST_RUN;
                end else if (r_to_cnt == TO_LAST) begin
                    w_to_expire  = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_pc_write      = 1'b0;
                    w_if_id_write   = 1'b0;
                    w_id_ex_write   = 1'b0;
                    w_ex_mem_bubble = 1'b1;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Held at zero in RUN so every MC_WAIT entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_MC_WAIT) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_to_expire) begin
            r_timeout_err <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~w_pc_write),
        .count (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (w_flush_cnt)
    );

    assign bus.pc_write       = w_pc_write;
    assign bus.if_id_write    = w_if_id_write;
    assign bus.if_id_flush    = w_if_id_flush;
    assign bus.id_ex_write    = w_id_ex_write;
    assign bus.id_ex_flush    = w_id_ex_flush;
    assign bus.ex_mem_bubble  = w_ex_mem_bubble;
    assign bus.mc_busy        = (r_state == ST_MC_WAIT);
    assign bus.mc_timeout_err = r_timeout_err;
    assign bus.stall_cycles   = w_stall_cnt;
    assign bus.flush_count    = w_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W      = 16;
    localparam int MC_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sc_inc = 1'b0;
    logic [2:0] sc_count;
    int         tests = 0;
    int         fails = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MC_TIMEOUT(MC_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hz_if)
    );

    sat_counter #(.CNT_W(3)) u_small_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sc_inc),
        .count (sc_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        hz_if.if_id_rs1        = '0;
        hz_if.if_id_rs2        = '0;
        hz_if.if_id_uses_rs1   = 1'b0;
        hz_if.if_id_uses_rs2   = 1'b0;
        hz_if.id_ex_MemRead    = 1'b0;
        hz_if.id_ex_RegisterRd = '0;
        hz_if.ex_branch_taken  = 1'b0;
        hz_if.ex_mc_start      = 1'b0;
        hz_if.ex_mc_done       = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #2;
        tests++; if (hz_if.pc_write !== 1'b1) begin fails++; $display("FAIL rst_pc_write: got %b expected 1", hz_if.pc_write); end
        tests++; if (hz_if.if_id_write !== 1'b1 || hz_if.id_ex_write !== 1'b1) begin fails++; $display("FAIL rst_writes: got %b%b expected 11", hz_if.if_id_write, hz_if.id_ex_write); end
        tests++; if ({hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.ex_mem_bubble} !== 3'b000) begin fails++; $display("FAIL rst_flushes: got %b%b%b expected 000", hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.ex_mem_bubble); end
        tests++; if (hz_if.mc_busy !== 1'b0 || hz_if.mc_timeout_err !== 1'b0) begin fails++; $display("FAIL rst_flags: got busy=%b err=%b expected 0 0", hz_if.mc_busy, hz_if.mc_timeout_err); end
        tests++; if (hz_if.stall_cycles !== 16'd0 || hz_if.flush_count !== 16'd0) begin fails++; $display("FAIL rst_counters: got %0d %0d expected 0 0", hz_if.stall_cycles, hz_if.flush_count); end
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk);
        hz_if.id_ex_MemRead = 1'b1; hz_if.id_ex_RegisterRd = 5'd5;
        hz_if.if_id_rs1 = 5'd5; hz_if.if_id_uses_rs1 = 1'b1;
        hz_if.if_id_rs2 = 5'd6; hz_if.if_id_uses_rs2 = 1'b1;
        #2;
        tests++; if ({hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_flush} !== 3'b001) begin fails++; $display("FAIL lu_stall: got pc/ifid/flush=%b%b%b expected 001", hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_flush); end
        tests++; if (hz_if.id_ex_write !== 1'b1 || hz_if.ex_mem_bubble !== 1'b0) begin fails++; $display("FAIL lu_idex: got write=%b bubble=%b expected 1 0", hz_if.id_ex_write, hz_if.ex_mem_bubble); end
        @(negedge clk);
        idle();
        #2;
        tests++; if (hz_if.pc_write !== 1'b1 || hz_if.id_ex_flush !== 1'b0) begin fails++; $display("FAIL lu_release: got pc=%b flush=%b expected 1 0", hz_if.pc_write, hz_if.id_ex_flush); end
        tests++; if (hz_if.stall_cycles !== 16'd1) begin fails++; $display("FAIL lu_stall_cnt: got %0d expected 1", hz_if.stall_cycles); end
    endtask

    task automatic test_no_stall();
        apply_reset();
        @(negedge clk);
        hz_if.id_ex_MemRead = 1'b1; hz_if.id_ex_RegisterRd = 5'd0;
        hz_if.if_id_rs1 = 5'd0; hz_if.if_id_uses_rs1 = 1'b1;
        #2;
        tests++; if (hz_if.pc_write !== 1'b1 || hz_if.id_ex_flush !== 1'b0) begin fails++; $display("FAIL ns_rd0: got pc=%b flush=%b expected 1 0", hz_if.pc_write, hz_if.id_ex_flush); end
        @(negedge clk);
        hz_if.id_ex_RegisterRd = 5'd7; hz_if.if_id_rs1 = 5'd3;
        hz_if.if_id_rs2 = 5'd7; hz_if.if_id_uses_rs2 = 1'b0;
        #2;
        tests++; if (hz_if.pc_write !== 1'b1 || hz_if.id_ex_flush !== 1'b0) begin fails++; $display("FAIL ns_unused_rs2: got pc=%b flush=%b expected 1 0", hz_if.pc_write, hz_if.id_ex_flush); end
        @(negedge clk);
        hz_if.if_id_uses_rs2 = 1'b1;
        #2;
        tests++; if (hz_if.pc_write !== 1'b0 || hz_if.id_ex_flush !== 1'b1) begin fails++; $display("FAIL ns_used_rs2: got pc=%b flush=%b expected 0 1", hz_if.pc_write, hz_if.id_ex_flush); end
        @(negedge clk);
        hz_if.id_ex_MemRead = 1'b0;
        #2;
        tests++; if (hz_if.pc_write !== 1'b1) begin fails++; $display("FAIL ns_not_load: got pc=%b expected 1", hz_if.pc_write); end
        tests++; if (hz_if.stall_cycles !== 16'd1) begin fails++; $display("FAIL ns_stall_cnt: got %0d expected 1", hz_if.stall_cycles); end
    endtask

    task automatic test_branch();
        apply_reset();
        @(negedge clk);
        hz_if.ex_branch_taken = 1'b1; hz_if.ex_mc_start = 1'b1;
        hz_if.id_ex_MemRead = 1'b1; hz_if.id_ex_RegisterRd = 5'd9;
        hz_if.if_id_rs1 = 5'd9; hz_if.if_id_uses_rs1 = 1'b1;
        #2;
        tests++; if ({hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.pc_write} !== 3'b111) begin fails++; $display("FAIL br_flush: got ifid/idex/pc=%b%b%b expected 111", hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.pc_write); end
        tests++; if (hz_if.ex_mem_bubble !== 1'b0 || hz_if.if_id_write !== 1'b1) begin fails++; $display("FAIL br_no_stall: got bubble=%b ifid_w=%b expected 0 1", hz_if.ex_mem_bubble, hz_if.if_id_write); end
        @(negedge clk);
        idle();
        #2;
        tests++; if (hz_if.flush_count !== 16'd1) begin fails++; $display("FAIL br_flush_cnt: got %0d expected 1", hz_if.flush_count); end
        tests++; if (hz_if.mc_busy !== 1'b0 || hz_if.stall_cycles !== 16'd0) begin fails++; $display("FAIL br_state: got busy=%b stalls=%0d expected 0 0", hz_if.mc_busy, hz_if.stall_cycles); end
    endtask

    task automatic test_mc_done();
        int bubbles;
        int busy_stall;
        apply_reset();
        bubbles = 0;
        busy_stall = 0;
        @(negedge clk);
        hz_if.ex_mc_start = 1'b1;
        #2;
        if (hz_if.ex_mem_bubble === 1'b1) bubbles++;
        tests++; if ({hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write, hz_if.mc_busy} !== 4'b0000) begin fails++; $display("FAIL mc_start: got pc/ifid/idex/busy=%b%b%b%b expected 0000", hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write, hz_if.mc_busy); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hz_if.ex_mc_start = 1'b0;
            #2;
            if (hz_if.ex_mem_bubble === 1'b1) bubbles++;
            if (hz_if.mc_busy === 1'b1 && hz_if.pc_write === 1'b0) busy_stall++;
        end
        tests++; if (bubbles != 5) begin fails++; $display("FAIL mc_bubbles: got %0d expected 5", bubbles); end
        tests++; if (busy_stall != 4) begin fails++; $display("FAIL mc_busy_cycles: got %0d expected 4", busy_stall); end
        @(negedge clk);
        hz_if.ex_mc_done = 1'b1;
        #2;
        tests++; if ({hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write, hz_if.ex_mem_bubble} !== 4'b1110) begin fails++; $display("FAIL mc_done_release: got pc/ifid/idex/bubble=%b%b%b%b expected 1110", hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write, hz_if.ex_mem_bubble); end
        @(negedge clk);
        #2;
        tests++; if (hz_if.mc_busy !== 1'b0 || hz_if.pc_write !== 1'b1) begin fails++; $display("FAIL mc_late_done: got busy=%b pc=%b expected 0 1", hz_if.mc_busy, hz_if.pc_write); end
        tests++; if (hz_if.stall_cycles !== 16'd5 || hz_if.mc_timeout_err !== 1'b0) begin fails++; $display("FAIL mc_counts: got stalls=%0d err=%b expected 5 0", hz_if.stall_cycles, hz_if.mc_timeout_err); end
        @(negedge clk);
        hz_if.ex_mc_done = 1'b0;
        hz_if.ex_mc_start = 1'b1;
        hz_if.ex_mc_done = 1'b1;
        #2;
        tests++; if (hz_if.pc_write !== 1'b1 || hz_if.ex_mem_bubble !== 1'b0) begin fails++; $display("FAIL mc_single_cycle: got pc=%b bubble=%b expected 1 0", hz_if.pc_write, hz_if.ex_mem_bubble); end
        @(negedge clk);
        idle();
        #2;
        tests++; if (hz_if.mc_busy !== 1'b0) begin fails++; $display("FAIL mc_single_state: got busy=%b expected 0", hz_if.mc_busy); end
    endtask

    task automatic test_timeout();
        int stalled;
        apply_reset();
        stalled = 0;
        @(negedge clk);
        hz_if.ex_mc_start = 1'b1;
        for (int i = 1; i < MC_TIMEOUT; i++) begin
            @(negedge clk);
            hz_if.ex_mc_start = 1'b0;
            #2;
            if (hz_if.mc_busy === 1'b1 && hz_if.ex_mem_bubble === 1'b1) stalled++;
        end
        tests++; if (stalled != MC_TIMEOUT - 1) begin fails++; $display("FAIL to_wait_cycles: got %0d expected %0d", stalled, MC_TIMEOUT - 1); end
        tests++; if (hz_if.mc_timeout_err !== 1'b0) begin fails++; $display("FAIL to_err_early: got %b expected 0", hz_if.mc_timeout_err); end
        @(negedge clk);
        #2;
        tests++; if ({hz_if.mc_busy, hz_if.pc_write, hz_if.ex_mem_bubble} !== 3'b110) begin fails++; $display("FAIL to_release: got busy/pc/bubble=%b%b%b expected 110", hz_if.mc_busy, hz_if.pc_write, hz_if.ex_mem_bubble); end
        @(negedge clk);
        #2;
        tests++; if (hz_if.mc_busy !== 1'b0 || hz_if.mc_timeout_err !== 1'b1) begin fails++; $display("FAIL to_err_set: got busy=%b err=%b expected 0 1", hz_if.mc_busy, hz_if.mc_timeout_err); end
        repeat (3) @(negedge clk);
        #2;
        tests++; if (hz_if.mc_timeout_err !== 1'b1) begin fails++; $display("FAIL to_err_sticky: got %b expected 1", hz_if.mc_timeout_err); end
        tests++; if (hz_if.stall_cycles !== 16'd8) begin fails++; $display("FAIL to_stall_cnt: got %0d expected 8", hz_if.stall_cycles); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        @(negedge clk);
        hz_if.ex_mc_start = 1'b1;
        @(negedge clk);
        hz_if.ex_mc_start = 1'b0;
        @(negedge clk);
        #2;
        tests++; if (hz_if.mc_busy !== 1'b1 || hz_if.pc_write !== 1'b0) begin fails++; $display("FAIL rm_in_wait: got busy=%b pc=%b expected 1 0", hz_if.mc_busy, hz_if.pc_write); end
        rst_n = 1'b0;
        #1;
        tests++; if ({hz_if.mc_busy, hz_if.pc_write, hz_if.ex_mem_bubble} !== 3'b010) begin fails++; $display("FAIL rm_async: got busy/pc/bubble=%b%b%b expected 010", hz_if.mc_busy, hz_if.pc_write, hz_if.ex_mem_bubble); end
        tests++; if (hz_if.stall_cycles !== 16'd0 || hz_if.mc_timeout_err !== 1'b0) begin fails++; $display("FAIL rm_counters: got stalls=%0d err=%b expected 0 0", hz_if.stall_cycles, hz_if.mc_timeout_err); end
        @(negedge clk);
        rst_n = 1'b1;
        hz_if.ex_mc_done = 1'b1;
        #2;
        tests++; if (hz_if.mc_busy !== 1'b0 || hz_if.pc_write !== 1'b1) begin fails++; $display("FAIL rm_after: got busy=%b pc=%b expected 0 1", hz_if.mc_busy, hz_if.pc_write); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        @(negedge clk);
        sc_inc = 1'b1;
        repeat (6) @(negedge clk);
        tests++; if (sc_count !== 3'd6) begin fails++; $display("FAIL sat_count6: got %0d expected 6", sc_count); end
        repeat (4) @(negedge clk);
        tests++; if (sc_count !== 3'd7) begin fails++; $display("FAIL sat_hold: got %0d expected 7", sc_count); end
        sc_inc = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mc_done();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
